// File: rtl/rst_seq_ctrl_if.sv
// rtl/rst_seq_ctrl_if.sv - trigger/status bundle between reset requesters and rst_seq_ctrl
//
// Purpose : groups the reset request inputs and the staged reset / status
//           outputs of rst_seq_ctrl so they travel as a single port.
// Signals : i_sw_rst_req  software reset request level (rising edge triggers)
//           i_wdt_rst     watchdog reset pulse (any high cycle triggers)
//           i_ext_rst_n   external reset pin, asynchronous, active-low
//           i_cause_clr   synchronous clear of o_cause
//           o_rst_n       staged active-low domain resets, bit0 released first
//           o_busy        high while any o_rst_n bit is low
//           o_cause       sticky cause {por, ext, wdt, sw}
// Modports: master - the requester side (drives requests, observes status)
//           slave  - the sequencer side (rst_seq_ctrl)

interface rst_seq_ctrl_if #(
    parameter int P_NUM_DOM = 3
) ();

    logic                 i_sw_rst_req;
    logic                 i_wdt_rst;
    logic                 i_ext_rst_n;
    logic                 i_cause_clr;
    logic [P_NUM_DOM-1:0] o_rst_n;
    logic                 o_busy;
    logic [3:0]           o_cause;

    modport master (
        output i_sw_rst_req,
        output i_wdt_rst,
        output i_ext_rst_n,
        output i_cause_clr,
        input  o_rst_n,
        input  o_busy,
        input  o_cause
    );

    modport slave (
        input  i_sw_rst_req,
        input  i_wdt_rst,
        input  i_ext_rst_n,
        input  i_cause_clr,
        output o_rst_n,
        output o_busy,
        output o_cause
    );

endinterface

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - staged multi-domain reset sequencer with sticky cause capture
//
// Purpose : holds all domain resets asserted for P_HOLD_CYC cycles after any
//           reset trigger, then releases the domains one at a time, bit0
//           first, P_STEP_CYC cycles apart.  Triggers are a software request
//           rising edge, a watchdog pulse, the synchronized external pin, and
//           the asynchronous power-on reset i_reset.
// Ports   : i_clkin  clock, all logic on its rising edge
//           i_reset  asynchronous active-low power-on reset
//           bus      rst_seq_ctrl_if.slave (requests in, o_rst_n/o_busy/o_cause out)
// Params  : P_HOLD_CYC  all-domain assertion length in cycles (>= 2)
//           P_STEP_CYC  cycles between successive domain releases (>= 1)
//           P_NUM_DOM   number of staged reset outputs (>= 1)

module rst_seq_ctrl #(
    parameter int P_HOLD_CYC = 16,
    parameter int P_STEP_CYC = 4,
    parameter int P_NUM_DOM  = 3
) (
    input  logic           i_clkin,
    input  logic           i_reset,
    rst_seq_ctrl_if.slave  bus
);

    // One counter times both the hold phase and the release steps, so it is
    // sized for whichever terminal count is larger.
    localparam int C_CNT_MAX = (P_HOLD_CYC > P_STEP_CYC) ? P_HOLD_CYC : P_STEP_CYC;
    localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;

    localparam logic [C_CNT_W-1:0] C_HOLD_LAST = C_CNT_W'(P_HOLD_CYC - 1);
    localparam logic [C_CNT_W-1:0] C_STEP_LAST = C_CNT_W'(P_STEP_CYC - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t               r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [P_NUM_DOM-1:0] r_rst_n;
    logic                 r_busy;
    logic [3:0]           r_cause;
    logic                 r_sw_prev;
    logic                 r_ext_meta;
    logic                 r_ext_sync;

    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   w_cnt_nxt;
    logic [P_NUM_DOM-1:0] w_rst_n_nxt;
    logic [P_NUM_DOM-1:0] w_rst_n_step;
    logic [3:0]           w_cause_nxt;
    logic                 w_sw_rise;
    logic                 w_ext_fall;
    logic                 w_ext_hold;
    logic                 w_trig;

    // ------------------------------------------------------------------
    // Trigger detection
    // ------------------------------------------------------------------
    assign w_sw_rise = bus.i_sw_rst_req & ~r_sw_prev;

    // The sequencer holds ASSERT while either synchronizer stage reads low.
    // Looking at the first stage lets the domains drop on the second edge
    // after the pin falls; looking at the second stage keeps the hold count
    // at zero until the synchronized value itself has returned to 1.
    assign w_ext_hold = ~r_ext_meta | ~r_ext_sync;

    // Only a genuine 1->0 transition of the pin records an ext cause; the
    // synchronizer reading 0 straight out of power-on reset does not.
    assign w_ext_fall = r_ext_sync & ~r_ext_meta;

    assign w_trig = w_sw_rise | bus.i_wdt_rst | w_ext_hold;

    // A set arriving together with a clear wins for its own bit only.
    assign w_cause_nxt = (bus.i_cause_clr ? 4'b0000 : r_cause)
                       | {1'b0, w_ext_fall, bus.i_wdt_rst, w_sw_rise};

    // ------------------------------------------------------------------
    // Next release pattern: the outputs always form a thermometer code
    // growing from bit0, so the next pattern is the current one shifted
    // up with a 1 entering at bit0.  From all-zeros this releases bit0.
    // ------------------------------------------------------------------
    always_comb begin
        w_rst_n_step    = '0;
        w_rst_n_step[0] = 1'b1;
        for (int k = 1; k < P_NUM_DOM; k++) begin
            w_rst_n_step[k] = r_rst_n[k-1];
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rst_n_nxt = r_rst_n;

        if (w_trig) begin
            // Any trigger, in any state, restarts the full hold.
            w_state_nxt = ST_ASSERT;
            w_cnt_nxt   = '0;
            w_rst_n_nxt = '0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (r_cnt == C_HOLD_LAST) begin
                        w_rst_n_nxt = w_rst_n_step;
                        w_cnt_nxt   = '0;
                        // With a single domain, releasing bit0 finishes the sequence.
                        w_state_nxt = (&w_rst_n_step) ? ST_DONE : ST_RELEASE;
                    end else begin
                        w_cnt_nxt = r_cnt + C_CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == C_STEP_LAST) begin
                        w_rst_n_nxt = w_rst_n_step;
                        w_cnt_nxt   = '0;
                        w_state_nxt = (&w_rst_n_step) ? ST_DONE : ST_RELEASE;
                    end else begin
                        w_cnt_nxt = r_cnt + C_CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt = ST_ASSERT;
                    w_cnt_nxt   = '0;
                    w_rst_n_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clkin or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_ASSERT;
            r_cnt      <= '0;
            r_rst_n    <= '0;
            r_busy     <= 1'b1;
            r_cause    <= 4'b1000;
            r_sw_prev  <= 1'b0;
            r_ext_meta <= 1'b0;
            r_ext_sync <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rst_n    <= w_rst_n_nxt;
            // Registered from the same next value so it falls on the very
            // edge the last domain is released.
            r_busy     <= ~&w_rst_n_nxt;
            r_cause    <= w_cause_nxt;
            r_sw_prev  <= bus.i_sw_rst_req;
            r_ext_meta <= bus.i_ext_rst_n;
            r_ext_sync <= r_ext_meta;
        end
    end

    assign bus.o_rst_n = r_rst_n;
    assign bus.o_busy  = r_busy;
    assign bus.o_cause = r_cause;

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_busy_matches: assert property (@(posedge i_clkin) disable iff (!i_reset)
        r_busy == ~&r_rst_n);

    // Released bits must be a contiguous run starting at bit0.
    a_in_order: assert property (@(posedge i_clkin) disable iff (!i_reset)
        (r_rst_n & (r_rst_n + P_NUM_DOM'(1))) == '0);

    a_done_all_released: assert property (@(posedge i_clkin) disable iff (!i_reset)
        (r_state == ST_DONE) |-> (&r_rst_n));

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - self-checking bench for rst_seq_ctrl with an edge-age reference model

module tb_rst_seq_ctrl;

    localparam int HOLD = 16;
    localparam int STEP = 4;
    localparam int ND   = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic sw   = 1'b0;
    logic wdt  = 1'b0;
    logic ext  = 1'b1;
    logic clr  = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: m_age counts edges since the most recent trigger edge;
    // domain k is released once m_age reaches HOLD + k*STEP.  m_h1/m_h2 are
    // the pin values sampled one and two edges ago.
    int       m_age;
    bit       m_h1;
    bit       m_h2;
    bit       m_swp;
    bit [3:0] m_cause;

    rst_seq_ctrl_if #(.P_NUM_DOM(ND)) bus ();

    assign bus.i_sw_rst_req = sw;
    assign bus.i_wdt_rst    = wdt;
    assign bus.i_ext_rst_n  = ext;
    assign bus.i_cause_clr  = clr;

    rst_seq_ctrl #(
        .P_HOLD_CYC (HOLD),
        .P_STEP_CYC (STEP),
        .P_NUM_DOM  (ND)
    ) dut (
        .i_clkin (clk),
        .i_reset (rstn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [ND-1:0] exp_rst();
        logic [ND-1:0] v;
        for (int k = 0; k < ND; k++) v[k] = (m_age >= HOLD + k * STEP);
        return v;
    endfunction

    task automatic model_reset();
        m_age   = 0;
        m_h1    = 1'b0;
        m_h2    = 1'b0;
        m_swp   = 1'b0;
        m_cause = 4'b1000;
    endtask

    task automatic model_edge();
        bit sw_rise, ext_trig, ext_fall, trig;
        sw_rise  = sw && !m_swp;
        ext_trig = !m_h1 || !m_h2;
        ext_fall = !m_h1 && m_h2;
        trig     = sw_rise || wdt || ext_trig;
        m_cause  = (clr ? 4'b0000 : m_cause) | {1'b0, ext_fall, wdt, sw_rise};
        if (trig) m_age = 0;
        else if (m_age < 100000) m_age++;
        m_h2  = m_h1;
        m_h1  = ext;
        m_swp = sw;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rstn) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) tick();
        checks++; if (bus.o_rst_n !== 3'b000) begin errors++; $display("FAIL reset_rst_n got %b exp 000", bus.o_rst_n); end
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", bus.o_busy); end
        checks++; if (bus.o_cause !== 4'b1000) begin errors++; $display("FAIL reset_cause got %b exp 1000", bus.o_cause); end
    endtask

    task automatic test_por(input string tag);
        #2 rstn = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            checks++; if (bus.o_rst_n !== exp_rst()) begin errors++; $display("FAIL %s_rst_n edge %0d got %b exp %b", tag, e, bus.o_rst_n, exp_rst()); end
            checks++; if (bus.o_busy !== ~&exp_rst()) begin errors++; $display("FAIL %s_busy edge %0d got %b exp %b", tag, e, bus.o_busy, ~&exp_rst()); end
            checks++; if (bus.o_cause !== 4'b1000) begin errors++; $display("FAIL %s_cause edge %0d got %b exp 1000", tag, e, bus.o_cause); end
            if (e == 17) begin checks++; if (bus.o_rst_n !== 3'b000) begin errors++; $display("FAIL %s_e17 got %b exp 000", tag, bus.o_rst_n); end end
            if (e == 18) begin checks++; if (bus.o_rst_n !== 3'b001) begin errors++; $display("FAIL %s_e18 got %b exp 001", tag, bus.o_rst_n); end end
            if (e == 22) begin checks++; if (bus.o_rst_n !== 3'b011) begin errors++; $display("FAIL %s_e22 got %b exp 011", tag, bus.o_rst_n); end end
            if (e == 25) begin checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL %s_e25_busy got %b exp 1", tag, bus.o_busy); end end
            if (e == 26) begin checks++; if (bus.o_rst_n !== 3'b111 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL %s_e26 got %b/%b exp 111/0", tag, bus.o_rst_n, bus.o_busy); end end
        end
    endtask

    task automatic test_sw_held();
        sw = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            if (i == 51) sw = 1'b0;
            tick();
            checks++; if (bus.o_rst_n !== exp_rst() || bus.o_cause !== m_cause) begin errors++; $display("FAIL sw_model cyc %0d got %b/%b exp %b/%b", i, bus.o_rst_n, bus.o_cause, exp_rst(), m_cause); end
            if (i == 1)  begin checks++; if (bus.o_rst_n !== 3'b000) begin errors++; $display("FAIL sw_assert got %b exp 000", bus.o_rst_n); end end
            if (i == 17) begin checks++; if (bus.o_rst_n !== 3'b001) begin errors++; $display("FAIL sw_rel0 got %b exp 001", bus.o_rst_n); end end
            if (i == 25) begin checks++; if (bus.o_rst_n !== 3'b111) begin errors++; $display("FAIL sw_rel2 got %b exp 111", bus.o_rst_n); end end
            if (i == 60) begin checks++; if (bus.o_rst_n !== 3'b111) begin errors++; $display("FAIL sw_no_retrigger got %b exp 111", bus.o_rst_n); end end
        end
        checks++; if (bus.o_cause !== 4'b1001) begin errors++; $display("FAIL sw_cause got %b exp 1001", bus.o_cause); end
    endtask

    task automatic test_cause_clr();
        clr = 1'b1;
        wdt = 1'b1;
        tick();
        clr = 1'b0;
        wdt = 1'b0;
        checks++; if (bus.o_cause !== 4'b0010) begin errors++; $display("FAIL clr_wdt_cause got %b exp 0010", bus.o_cause); end
        checks++; if (bus.o_cause !== m_cause) begin errors++; $display("FAIL clr_model_cause got %b exp %b", bus.o_cause, m_cause); end
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++; if (bus.o_rst_n !== exp_rst()) begin errors++; $display("FAIL clr_seq cyc %0d got %b exp %b", i, bus.o_rst_n, exp_rst()); end
        end
    endtask

    task automatic test_wdt_mid();
        bit found;
        sw = 1'b1;
        tick();
        sw = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            checks++; if (bus.o_rst_n !== exp_rst()) begin errors++; $display("FAIL wdt_pre cyc %0d got %b exp %b", i, bus.o_rst_n, exp_rst()); end
            if (bus.o_rst_n === 3'b001) found = 1'b1;
        end
        if (!found) begin checks++; errors++; $display("FAIL wdt_wait_001 got %b exp 001", bus.o_rst_n); end
        wdt = 1'b1;
        tick();
        wdt = 1'b0;
        checks++; if (bus.o_rst_n !== 3'b000) begin errors++; $display("FAIL wdt_assert got %b exp 000", bus.o_rst_n); end
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++; if (bus.o_rst_n !== ((i < 16) ? 3'b000 : 3'b001)) begin errors++; $display("FAIL wdt_hold cyc %0d got %b exp %b", i, bus.o_rst_n, (i < 16) ? 3'b000 : 3'b001); end
        end
        checks++; if (bus.o_cause[1] !== 1'b1 || bus.o_cause !== m_cause) begin errors++; $display("FAIL wdt_cause got %b exp %b", bus.o_cause, m_cause); end
        repeat (12) tick();
    endtask

    task automatic test_ext();
        checks++; if (bus.o_rst_n !== 3'b111) begin errors++; $display("FAIL ext_pre got %b exp 111", bus.o_rst_n); end
        ext = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++; if (bus.o_rst_n !== exp_rst()) begin errors++; $display("FAIL ext_low cyc %0d got %b exp %b", i, bus.o_rst_n, exp_rst()); end
            if (i == 1) begin checks++; if (bus.o_rst_n !== 3'b111) begin errors++; $display("FAIL ext_e1 got %b exp 111", bus.o_rst_n); end end
            if (i == 2) begin checks++; if (bus.o_rst_n !== 3'b000) begin errors++; $display("FAIL ext_e2 got %b exp 000", bus.o_rst_n); end end
        end
        ext = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++; if (bus.o_rst_n !== exp_rst()) begin errors++; $display("FAIL ext_rel cyc %0d got %b exp %b", i, bus.o_rst_n, exp_rst()); end
            if (i == 17) begin checks++; if (bus.o_rst_n !== 3'b000) begin errors++; $display("FAIL ext_r17 got %b exp 000", bus.o_rst_n); end end
            if (i == 18) begin checks++; if (bus.o_rst_n !== 3'b001) begin errors++; $display("FAIL ext_r18 got %b exp 001", bus.o_rst_n); end end
        end
        checks++; if (bus.o_cause[2] !== 1'b1 || bus.o_cause !== m_cause) begin errors++; $display("FAIL ext_cause got %b exp %b", bus.o_cause, m_cause); end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = (bus.o_rst_n === 3'b011);
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (bus.o_rst_n === 3'b011) found = 1'b1;
        end
        if (!found) begin checks++; errors++; $display("FAIL rstmid_wait_011 got %b exp 011", bus.o_rst_n); end
        #2 rstn = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.o_rst_n !== 3'b000) begin errors++; $display("FAIL rstmid_rst_n got %b exp 000", bus.o_rst_n); end
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b exp 1", bus.o_busy); end
        checks++; if (bus.o_cause !== 4'b1000) begin errors++; $display("FAIL rstmid_cause got %b exp 1000", bus.o_cause); end
        repeat (2) tick();
        test_por("rstmid_por");
    endtask

    task automatic test_random();
        int ext_left;
        ext_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) sw = ~sw;
            wdt = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 39) == 0);
            if (ext_left > 0) begin
                ext = 1'b0;
                ext_left--;
            end else begin
                ext = 1'b1;
                if ($urandom_range(0, 299) == 0) ext_left = $urandom_range(1, 12);
            end
            tick();
            checks++; if (bus.o_rst_n !== exp_rst() || bus.o_busy !== ~&exp_rst() || bus.o_cause !== m_cause) begin
                errors++;
                $display("FAIL rand cyc %0d got %b/%b/%b exp %b/%b/%b", i, bus.o_rst_n, bus.o_busy, bus.o_cause, exp_rst(), ~&exp_rst(), m_cause);
            end
        end
        sw = 1'b0; wdt = 1'b0; clr = 1'b0; ext = 1'b1;
    endtask

    initial begin
        test_reset();
        test_por("por");
        test_sw_held();
        test_cause_clr();
        test_wdt_mid();
        test_ext();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
